// File: rtl/flash_bus_bridge_pkg.sv
// flash_bus_bridge_pkg: shared FSM encoding, SPI opcodes and default timeout.
package flash_bus_bridge_pkg;
    typedef enum logic [2:0] {IDLE, CACHE, REQ, BUSY, DONE, HOLD} state_t;
    localparam logic SPI_RD = 1'b1;
    localparam logic SPI_WR = 1'b0;
    localparam int DEFAULT_TIMEOUT = 1023;
endpackage

// File: rtl/flash_bus_bridge_e_sync_edge.sv
// e_sync_edge: 2-flop synchronizer for the 6809 E clock with edge strobes.
module e_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_e,
    output logic o_rise,
    output logic o_fall
);
    logic s1_q, s1_d, s2_q, s2_d;

    always_comb begin
        s1_d = reset ? i_e : 1'b0;
        s2_d = reset ? s1_q : 1'b0;
    end

    always_ff @(posedge clk) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
    end

    // Strobes come from the flop pair so the FSM acts on the second edge after E rises.
    assign o_rise = s1_q & ~s2_q;
    assign o_fall = ~s1_q & s2_q;
endmodule

// File: rtl/flash_bus_bridge.sv
// flash_bus_bridge: 6809 bus to SPI flash controller bridge with a one-byte read cache.
module flash_bus_bridge
    import flash_bus_bridge_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hE000,
    parameter int          TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic [7:0]  i_DataBus,
    input  logic        i_RW,
    input  logic        i_E,
    output logic [7:0]  o_cpu_data,
    output logic        o_cpu_data_oe,
    output logic        o_MRDY,
    output logic        o_spi_ce,
    output logic [15:0] o_spi_addr,
    output logic        o_spi_rw,
    output logic [7:0]  o_spi_wdata,
    input  logic [7:0]  i_spi_data,
    input  logic        i_spi_ready,
    output logic        o_timeout
);
    localparam logic [9:0] TMO = 10'(TIMEOUT);

    state_t      state_q;
    logic        rd_q, cache_valid_q;
    logic [11:0] cache_tag_q;
    logic [7:0]  cache_data_q;
    logic [9:0]  cnt_q;
    logic        e_rise, e_fall, hit, cache_hit, expired;

    e_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_e    (i_E),
        .o_rise (e_rise),
        .o_fall (e_fall)
    );

    assign hit       = i_ADDRESS_BUS[15:12] == BASE_ADDR[15:12];
    assign cache_hit = i_RW && cache_valid_q && cache_tag_q == i_ADDRESS_BUS[11:0];
    assign expired   = (state_q == REQ || state_q == BUSY) && cnt_q == TMO;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            rd_q          <= 1'b1;
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
            cnt_q         <= '0;
            o_cpu_data    <= '0;
            o_cpu_data_oe <= 1'b0;
            o_MRDY        <= 1'b1;
            o_spi_ce      <= 1'b0;
            o_spi_addr    <= '0;
            o_spi_rw      <= SPI_RD;
            o_spi_wdata   <= '0;
            o_timeout     <= 1'b0;
        end else if (expired) begin
            o_spi_ce      <= 1'b0;
            o_timeout     <= 1'b1;
            o_cpu_data    <= 8'hFF;
            o_MRDY        <= 1'b1;
            o_cpu_data_oe <= rd_q;
            state_q       <= HOLD;
        end else begin
            case (state_q)
                IDLE: if (e_rise && hit) begin
                    o_MRDY <= 1'b0;
                    rd_q   <= i_RW;
                    if (cache_hit) state_q <= CACHE;
                    else begin
                        state_q     <= REQ;
                        o_spi_ce    <= 1'b1;
                        o_spi_addr  <= i_ADDRESS_BUS;
                        o_spi_rw    <= i_RW ? SPI_RD : SPI_WR;
                        o_spi_wdata <= i_DataBus;
                        cnt_q       <= '0;
                    end
                end
                CACHE: begin
                    o_cpu_data    <= cache_data_q;
                    o_MRDY        <= 1'b1;
                    o_cpu_data_oe <= 1'b1;
                    state_q       <= HOLD;
                end
                REQ: begin
                    cnt_q <= cnt_q + 10'd1;
                    if (!i_spi_ready) begin
                        o_spi_ce <= 1'b0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 10'd1;
                    if (i_spi_ready) state_q <= DONE;
                end
                DONE: begin
                    if (rd_q) begin
                        o_cpu_data   <= i_spi_data;
                        cache_data_q <= i_spi_data;
                        cache_tag_q  <= o_spi_addr[11:0];
                    end
                    cache_valid_q <= rd_q;
                    o_MRDY        <= 1'b1;
                    o_cpu_data_oe <= rd_q;
                    state_q       <= HOLD;
                end
                HOLD: if (e_fall) begin
                    o_cpu_data_oe <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_bus_bridge.sv
// tb_flash_bus_bridge: directed checks of the bridge against a simple SPI controller model.
module tb_flash_bus_bridge;
    logic        clk = 0, reset = 0;
    logic [15:0] i_ADDRESS_BUS = 0;
    logic [7:0]  i_DataBus = 0, i_spi_data = 0;
    logic        i_RW = 1, i_E = 0, i_spi_ready = 1;
    logic [7:0]  o_cpu_data, o_spi_wdata;
    logic        o_cpu_data_oe, o_MRDY, o_spi_ce, o_spi_rw, o_timeout;
    logic [15:0] o_spi_addr;

    int vectors = 0, errors = 0;
    int ce_cnt, mrdy_low, oe_seen, mc;
    logic [15:0] cap_addr;
    logic        cap_rw;
    logic [7:0]  cap_wdata, spi_val, rd;
    bit          busy = 0, hang = 0;
    logic        got_rdy, oe_hi, oe_lo;

    flash_bus_bridge dut (
        .clk(clk), .reset(reset), .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_DataBus(i_DataBus),
        .i_RW(i_RW), .i_E(i_E), .o_cpu_data(o_cpu_data), .o_cpu_data_oe(o_cpu_data_oe),
        .o_MRDY(o_MRDY), .o_spi_ce(o_spi_ce), .o_spi_addr(o_spi_addr), .o_spi_rw(o_spi_rw),
        .o_spi_wdata(o_spi_wdata), .i_spi_data(i_spi_data), .i_spi_ready(i_spi_ready),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    // Controller model: drops ready when started, returns spi_val 80 cycles later unless hung.
    always @(negedge clk) begin
        if (!reset) begin
            busy = 0;
            i_spi_ready = 1;
        end else if (!busy && o_spi_ce) begin
            busy = 1;
            mc = 0;
            i_spi_ready = 0;
        end else if (busy && !hang) begin
            mc++;
            if (mc >= 80) begin
                i_spi_data = spi_val;
                i_spi_ready = 1;
                busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (o_spi_ce) begin
            ce_cnt++;
            cap_addr = o_spi_addr;
            cap_rw = o_spi_rw;
            cap_wdata = o_spi_wdata;
        end
        if (!o_MRDY) mrdy_low++;
        if (o_cpu_data_oe) oe_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd);
        int n;
        @(negedge clk);
        i_ADDRESS_BUS = a;
        i_RW = rw;
        i_DataBus = wd;
        ce_cnt = 0;
        mrdy_low = 0;
        oe_seen = 0;
        i_E = 1;
        repeat (4) @(negedge clk);
        n = 0;
        while (!o_MRDY && n < 3000) begin
            @(negedge clk);
            n++;
        end
        got_rdy = o_MRDY;
        repeat (2) @(negedge clk);
        rd = o_cpu_data;
        oe_hi = o_cpu_data_oe;
        i_E = 0;
        repeat (4) @(negedge clk);
        oe_lo = o_cpu_data_oe;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mrdy"}, o_MRDY, 1);
        check({tag, "_ce"}, o_spi_ce, 0);
        check({tag, "_oe"}, o_cpu_data_oe, 0);
        check({tag, "_data"}, o_cpu_data, 0);
        check({tag, "_addr"}, o_spi_addr, 0);
        check({tag, "_rw"}, o_spi_rw, 1);
        check({tag, "_wdata"}, o_spi_wdata, 0);
        check({tag, "_timeout"}, o_timeout, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1;
        repeat (2) @(negedge clk);

        spi_val = 8'h5A;
        bus_cycle(16'hE123, 1, 0);
        check("miss_rdy", got_rdy, 1);
        check("miss_ce", ce_cnt > 0, 1);
        check("miss_addr", cap_addr, 16'hE123);
        check("miss_rw", cap_rw, 1);
        check("miss_stretch", mrdy_low > 80, 1);
        check("miss_data", rd, 8'h5A);
        check("miss_oe_hi", oe_hi, 1);
        check("miss_oe_lo", oe_lo, 0);

        spi_val = 8'h11;
        bus_cycle(16'hE123, 1, 0);
        check("hit_ce", ce_cnt, 0);
        check("hit_stretch", mrdy_low, 1);
        check("hit_data", rd, 8'h5A);
        check("hit_oe_hi", oe_hi, 1);

        bus_cycle(16'hE123, 0, 8'hC3);
        check("wr_ce", ce_cnt > 0, 1);
        check("wr_rw", cap_rw, 0);
        check("wr_wdata", cap_wdata, 8'hC3);
        check("wr_addr", cap_addr, 16'hE123);
        check("wr_oe", oe_seen, 0);
        check("wr_rdy", got_rdy, 1);

        spi_val = 8'h77;
        bus_cycle(16'hE123, 1, 0);
        check("rdw_ce", ce_cnt > 0, 1);
        check("rdw_data", rd, 8'h77);

        bus_cycle(16'h8000, 1, 0);
        check("off_ce", ce_cnt, 0);
        check("off_mrdy", mrdy_low, 0);
        check("off_oe", oe_seen, 0);

        hang = 1;
        bus_cycle(16'hE300, 1, 0);
        check("tmo_rdy", got_rdy, 1);
        check("tmo_flag", o_timeout, 1);
        check("tmo_data", rd, 8'hFF);
        check("tmo_oe_hi", oe_hi, 1);
        check("tmo_stretch", mrdy_low > 1000, 1);
        check("tmo_ce_once", ce_cnt < 3, 1);
        hang = 0;

        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst2");
        reset = 1;
        repeat (2) @(negedge clk);

        spi_val = 8'h99;
        i_ADDRESS_BUS = 16'hE200;
        i_RW = 1;
        i_E = 1;
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_reached", busy, 1);
        repeat (10) @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        check("rstbusy_ce", o_spi_ce, 0);
        check("rstbusy_mrdy", o_MRDY, 1);
        @(negedge clk);
        reset = 1;
        i_E = 0;
        repeat (4) @(negedge clk);

        spi_val = 8'h42;
        bus_cycle(16'hE123, 1, 0);
        check("post_rst_miss", ce_cnt > 0, 1);
        check("post_rst_data", rd, 8'h42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
